// File: rtl/ins_mem_issue_if.sv
// Bundle-in / beat-out bus of the memory-op issue stage.
// slave = issue stage view, master = producer/consumer (bench) view.
interface ins_mem_issue_if;
  logic       in_valid, in_ready;
  logic       in_1_vld, in_2_vld, in_3_vld, in_4_vld;
  logic [3:0] in_1_des, in_1_s1, in_1_s2, in_1_op, in_1_ime;
  logic [3:0] in_2_des, in_2_s1, in_2_s2, in_2_op, in_2_ime;
  logic [3:0] in_3_des, in_3_s1, in_3_s2, in_3_op, in_3_ime;
  logic [3:0] in_4_des, in_4_s1, in_4_s2, in_4_op, in_4_ime;
  logic [2:0] in_1_branch, in_2_branch, in_3_branch, in_4_branch;

  logic       out_valid, out_ready;
  logic       out_1_vld, out_2_vld, out_3_vld, out_4_vld;
  logic [3:0] out_1_des, out_1_s1, out_1_s2, out_1_op, out_1_ime;
  logic [3:0] out_2_des, out_2_s1, out_2_s2, out_2_op, out_2_ime;
  logic [3:0] out_3_des, out_3_s1, out_3_s2, out_3_op, out_3_ime;
  logic [3:0] out_4_des, out_4_s1, out_4_s2, out_4_op, out_4_ime;
  logic [2:0] out_1_branch, out_2_branch, out_3_branch, out_4_branch;

  logic        ins1_swap, ins2_swap, ins3_swap, ins4_swap;
  logic        split_active;
  logic [15:0] bundle_cnt, split_cnt;

  modport slave (
    input  in_valid, out_ready,
    input  in_1_vld, in_1_des, in_1_s1, in_1_s2, in_1_op, in_1_branch, in_1_ime,
    input  in_2_vld, in_2_des, in_2_s1, in_2_s2, in_2_op, in_2_branch, in_2_ime,
    input  in_3_vld, in_3_des, in_3_s1, in_3_s2, in_3_op, in_3_branch, in_3_ime,
    input  in_4_vld, in_4_des, in_4_s1, in_4_s2, in_4_op, in_4_branch, in_4_ime,
    output in_ready, out_valid,
    output out_1_vld, out_1_des, out_1_s1, out_1_s2, out_1_op, out_1_branch, out_1_ime,
    output out_2_vld, out_2_des, out_2_s1, out_2_s2, out_2_op, out_2_branch, out_2_ime,
    output out_3_vld, out_3_des, out_3_s1, out_3_s2, out_3_op, out_3_branch, out_3_ime,
    output out_4_vld, out_4_des, out_4_s1, out_4_s2, out_4_op, out_4_branch, out_4_ime,
    output ins1_swap, ins2_swap, ins3_swap, ins4_swap, split_active,
    output bundle_cnt, split_cnt
  );

  modport master (
    output in_valid, out_ready,
    output in_1_vld, in_1_des, in_1_s1, in_1_s2, in_1_op, in_1_branch, in_1_ime,
    output in_2_vld, in_2_des, in_2_s1, in_2_s2, in_2_op, in_2_branch, in_2_ime,
    output in_3_vld, in_3_des, in_3_s1, in_3_s2, in_3_op, in_3_branch, in_3_ime,
    output in_4_vld, in_4_des, in_4_s1, in_4_s2, in_4_op, in_4_branch, in_4_ime,
    input  in_ready, out_valid,
    input  out_1_vld, out_1_des, out_1_s1, out_1_s2, out_1_op, out_1_branch, out_1_ime,
    input  out_2_vld, out_2_des, out_2_s1, out_2_s2, out_2_op, out_2_branch, out_2_ime,
    input  out_3_vld, out_3_des, out_3_s1, out_3_s2, out_3_op, out_3_branch, out_3_ime,
    input  out_4_vld, out_4_des, out_4_s1, out_4_s2, out_4_op, out_4_branch, out_4_ime,
    input  ins1_swap, ins2_swap, ins3_swap, ins4_swap, split_active,
    input  bundle_cnt, split_cnt
  );
endinterface

// File: rtl/ins_mem_issue.sv
// Issue stage: splits a 4-slot bundle into beats holding at most one memory op and
// steers that op toward slot 4 via swap flags. ISSUE_STAT_EN enables bundle/split counters.
module ins_mem_issue (
  input  logic           clk,
  input  logic           rst_n,
  ins_mem_issue_if.slave bus,
  output logic [1:0]     state_dbg
);
  localparam logic [3:0] LD_OP = 4'b1000;
  localparam logic [3:0] ST_OP = 4'b1001;
  localparam int         PW    = 23;  // {des, s1, s2, op, branch, ime}

  typedef enum logic [1:0] {EMPTY = 2'd0, FIRST = 2'd1, FOLLOW = 2'd2} state_t;

  state_t        state;
  logic [3:0]    pend;
  logic [3:0]    beat_vld;   // bit i = slot i+1
  logic [3:0]    swap_q;     // bit i = ins<i+1>_swap
  logic          split_q;
  logic [PW-1:0] pay_q  [4];
  logic [PW-1:0] in_pay [4];
  logic [3:0]    in_vld, mem_in;
  logic [3:0]    pend_rest;
  logic          last, in_acc, out_acc;

  function automatic logic [3:0] lowest(input logic [3:0] m);
    return m & (~m + 4'd1);
  endfunction

  // A one-hot op in slots 1..3 pairs its own flag with ins4; slot 4 or none needs no swap.
  function automatic logic [3:0] swap_of(input logic [3:0] one);
    return (one[2:0] != 3'b000) ? {1'b1, one[2:0]} : 4'b0000;
  endfunction

  assign in_vld    = {bus.in_4_vld, bus.in_3_vld, bus.in_2_vld, bus.in_1_vld};
  assign in_pay[0] = {bus.in_1_des, bus.in_1_s1, bus.in_1_s2, bus.in_1_op, bus.in_1_branch, bus.in_1_ime};
  assign in_pay[1] = {bus.in_2_des, bus.in_2_s1, bus.in_2_s2, bus.in_2_op, bus.in_2_branch, bus.in_2_ime};
  assign in_pay[2] = {bus.in_3_des, bus.in_3_s1, bus.in_3_s2, bus.in_3_op, bus.in_3_branch, bus.in_3_ime};
  assign in_pay[3] = {bus.in_4_des, bus.in_4_s1, bus.in_4_s2, bus.in_4_op, bus.in_4_branch, bus.in_4_ime};

  always_comb begin
    mem_in = '0;
    for (int i = 0; i < 4; i++) begin
      mem_in[i] = in_vld[i] && ((in_pay[i][10:7] == LD_OP) || (in_pay[i][10:7] == ST_OP));
    end
  end

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // waits on ready, and a held beat stays stable until it is taken.
  assign pend_rest     = pend & ~lowest(pend);
  assign last          = (pend_rest == 4'b0000);
  assign bus.in_ready  = (state == EMPTY) || (bus.out_ready && last);
  assign bus.out_valid = (state != EMPTY);
  assign in_acc        = bus.in_valid && bus.in_ready;
  assign out_acc       = bus.out_valid && bus.out_ready;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      pend     <= '0;
      beat_vld <= '0;
      swap_q   <= '0;
      split_q  <= 1'b0;
      for (int i = 0; i < 4; i++) pay_q[i] <= '0;
    end else if (out_acc && !last) begin
      state    <= FOLLOW;
      pend     <= pend_rest;
      beat_vld <= lowest(pend_rest);
      swap_q   <= swap_of(lowest(pend_rest));
      split_q  <= 1'b1;
    end else if (in_acc) begin
      state    <= FIRST;
      pend     <= mem_in;
      beat_vld <= (in_vld & ~mem_in) | lowest(mem_in);
      swap_q   <= swap_of(lowest(mem_in));
      split_q  <= 1'b0;
      pay_q    <= in_pay;
    end else if (out_acc) begin
      state    <= EMPTY;
      split_q  <= 1'b0;
    end
  end

`ifdef ISSUE_STAT_EN
  logic [15:0] bundle_q, split_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q    <= '0;
      split_cnt_q <= '0;
    end else begin
      if (in_acc) bundle_q <= bundle_q + 16'd1;
      if (out_acc && (state == FOLLOW)) split_cnt_q <= split_cnt_q + 16'd1;
    end
  end
  assign bus.bundle_cnt = bundle_q;
  assign bus.split_cnt  = split_cnt_q;
`else
  assign bus.bundle_cnt = 16'd0;
  assign bus.split_cnt  = 16'd0;
`endif

  assign bus.split_active = split_q;
  assign {bus.ins4_swap, bus.ins3_swap, bus.ins2_swap, bus.ins1_swap} = swap_q;
  assign {bus.out_4_vld, bus.out_3_vld, bus.out_2_vld, bus.out_1_vld} = beat_vld;
  assign {bus.out_1_des, bus.out_1_s1, bus.out_1_s2, bus.out_1_op, bus.out_1_branch, bus.out_1_ime} = pay_q[0];
  assign {bus.out_2_des, bus.out_2_s1, bus.out_2_s2, bus.out_2_op, bus.out_2_branch, bus.out_2_ime} = pay_q[1];
  assign {bus.out_3_des, bus.out_3_s1, bus.out_3_s2, bus.out_3_op, bus.out_3_branch, bus.out_3_ime} = pay_q[2];
  assign {bus.out_4_des, bus.out_4_s1, bus.out_4_s2, bus.out_4_op, bus.out_4_branch, bus.out_4_ime} = pay_q[3];
endmodule
